// File: rtl/top_pkg.sv
// Shared pixel-path definitions for the RAW8 debayer and rgb2raw blocks.
// Holds the lane word type, Bayer phase enum, RGB field offsets and
// small helpers used when sizing and selecting samples.
package top_pkg;

  localparam int NUM_LANE = 2;

  // Lane 0 sits in bits [7:0] and carries the earliest pixel of the word.
  typedef logic [NUM_LANE-1:0][7:0] lane_raw_data_t;

  typedef enum logic [1:0] {
    PH_R,
    PH_GR,
    PH_GB,
    PH_B
  } bayer_phase_t;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // Counter width for values 0..n-1; never returns zero.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // RGGB tiling: even lines are R G R G ..., odd lines are G B G B ...
  function automatic bayer_phase_t bayer_phase(input logic line_odd, input logic pix_odd);
    case ({line_odd, pix_odd})
      2'b00:   return PH_R;
      2'b01:   return PH_GR;
      2'b10:   return PH_GB;
      default: return PH_B;
    endcase
  endfunction

endpackage

// File: rtl/rgb2raw_8_bayer_lane_pack.sv
// Packs 8-bit Bayer samples into NUM_LANE-wide words with line/frame markers.
// Latency: word registered 1 cycle after the sample that completes it.
// Backpressure: none; a partial word is held until more samples arrive.
//
// Ports: clk, rst (sync, active-high); sample_vld/sample_dat in;
// sol/sof mark the sample as first of line/frame (sampled on lane 0);
// data_out/data_valid/line_start/frame_start out, all registered.
module bayer_lane_pack
  import top_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           sample_vld,
  input  logic [7:0]     sample_dat,
  input  logic           sol,
  input  logic           sof,
  output lane_raw_data_t data_out,
  output logic           data_valid,
  output logic           line_start,
  output logic           frame_start
);

  localparam int IW = cnt_w(NUM_LANE);

  logic [IW-1:0]  lane_idx;
  lane_raw_data_t hold_q;
  lane_raw_data_t next_word;
  logic           sol_q;
  logic           sof_q;
  logic           first_lane;
  logic           last_lane;

  assign first_lane = (lane_idx == '0);
  assign last_lane  = (lane_idx == IW'(NUM_LANE - 1));

  // Holding register with the incoming sample merged into its lane, so the
  // completing sample goes straight to data_out without an extra cycle.
  always_comb begin
    next_word           = hold_q;
    next_word[lane_idx] = sample_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx    <= '0;
      hold_q      <= '0;
      sol_q       <= 1'b0;
      sof_q       <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (sample_vld) begin
        hold_q <= next_word;
        if (first_lane) begin
          sol_q <= sol;
          sof_q <= sof;
        end
        if (last_lane) begin
          lane_idx    <= '0;
          data_out    <= next_word;
          data_valid  <= 1'b1;
          // Markers belong to the lane-0 sample of this word.
          line_start  <= first_lane ? sol : sol_q;
          frame_start <= first_lane ? sof : sof_q;
        end else begin
          lane_idx <= lane_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rgb2raw_8.sv
// Re-mosaics RGB pixels into RGGB RAW8 lane words with line blanking.
// Latency: word out 1 cycle after the transfer that completes it.
// Backpressure: rgb_ready low for HBLANK cycles after each line; no downstream stall.
//
// Ports: clk, rst (sync, active-high); rgb_in/rgb_valid/rgb_ready pixel input;
// data_out/data_valid packed Bayer words; line_start/frame_start markers
// coincident with the word holding pixel 0 of a line / of line 0.
module rgb2raw_8
  import top_pkg::*;
#(
  parameter int LINE_LENGTH = 640,
  parameter int FRAME_LINES = 480,
  parameter int RGB_WIDTH   = 24,
  parameter int HBLANK      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RGB_WIDTH-1:0] rgb_in,
  input  logic                 rgb_valid,
  output logic                 rgb_ready,
  output lane_raw_data_t       data_out,
  output logic                 data_valid,
  output logic                 line_start,
  output logic                 frame_start
);

  if (LINE_LENGTH % NUM_LANE != 0) begin : g_chk_lane
    $error("LINE_LENGTH must be a multiple of NUM_LANE");
  end
  if ((LINE_LENGTH % 2 != 0) || (FRAME_LINES % 2 != 0)) begin : g_chk_even
    $error("LINE_LENGTH and FRAME_LINES must be even");
  end
  if (HBLANK < 1) begin : g_chk_blank
    $error("HBLANK must be at least 1");
  end
  if (RGB_WIDTH != 24) begin : g_chk_rgb
    $error("RGB_WIDTH must be 24");
  end

  localparam int PW = cnt_w(LINE_LENGTH);
  localparam int LW = cnt_w(FRAME_LINES);
  localparam int BW = cnt_w(HBLANK);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_BLANK
  } state_t;

  state_t        state;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic [BW-1:0] blank_cnt;
  logic          xfer;
  logic          last_pix;
  logic          last_line;
  logic [7:0]    sample;

  // rgb_ready is registered and only high in ACTIVE, so xfer never fires in IDLE/BLANK.
  assign xfer      = rgb_valid && rgb_ready;
  assign last_pix  = (pix_cnt == PW'(LINE_LENGTH - 1));
  assign last_line = (line_cnt == LW'(FRAME_LINES - 1));

  always_comb begin
    sample = '0;
    case (bayer_phase(line_cnt[0], pix_cnt[0]))
      PH_R:    sample = rgb_in[R_LSB +: 8];
      PH_GR,
      PH_GB:   sample = rgb_in[G_LSB +: 8];
      PH_B:    sample = rgb_in[B_LSB +: 8];
      default: sample = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rgb_ready <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      blank_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_ACTIVE;
          rgb_ready <= 1'b1;
        end
        ST_ACTIVE: begin
          if (xfer) begin
            if (last_pix) begin
              pix_cnt   <= '0;
              line_cnt  <= last_line ? '0 : line_cnt + 1'b1;
              blank_cnt <= '0;
              rgb_ready <= 1'b0;
              state     <= ST_BLANK;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        ST_BLANK: begin
          if (blank_cnt == BW'(HBLANK - 1)) begin
            rgb_ready <= 1'b1;
            state     <= ST_ACTIVE;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rgb_ready <= 1'b0;
        end
      endcase
    end
  end

  bayer_lane_pack u_pack (
    .clk         (clk),
    .rst         (rst),
    .sample_vld  (xfer),
    .sample_dat  (sample),
    .sol         (pix_cnt == '0),
    .sof         ((pix_cnt == '0) && (line_cnt == '0)),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

endmodule

// File: tb/tb_rgb2raw_8.sv
module tb_rgb2raw_8;
  import top_pkg::*;

  localparam int LL = 4;
  localparam int FL = 2;
  localparam int HB = 3;
  localparam int WW = NUM_LANE * 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [23:0]    rgb_in = '0;
  logic           rgb_valid = 1'b0;
  logic           rgb_ready;
  lane_raw_data_t data_out;
  logic           data_valid;
  logic           line_start;
  logic           frame_start;

  always #5 clk = ~clk;

  rgb2raw_8 #(
    .LINE_LENGTH (LL),
    .FRAME_LINES (FL),
    .RGB_WIDTH   (24),
    .HBLANK      (HB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rgb_in      (rgb_in),
    .rgb_valid   (rgb_valid),
    .rgb_ready   (rgb_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: position in the image, partially filled word, blanking left.
  int          m_pix, m_line, m_lane, blank_left;
  logic [7:0]  m_buf [NUM_LANE];
  logic        m_ls, m_fs;
  logic        exp_ready, exp_dv, exp_ls, exp_fs;
  logic [WW-1:0] exp_word;
  logic        last_xfer, obs_ready;
  logic [WW+1:0] obs_q [$];   // {line_start, frame_start, word}

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input logic v, input logic [23:0] d);
    logic [WW-1:0] w;
    logic [7:0]    s;
    w = data_out;
    obs_ready = rgb_ready;
    total++;
    if (rgb_ready !== exp_ready) begin
      bad++; $display("FAIL rgb_ready: got %b want %b at %0t", rgb_ready, exp_ready, $time);
    end
    total++;
    if (data_valid !== exp_dv) begin
      bad++; $display("FAIL data_valid: got %b want %b at %0t", data_valid, exp_dv, $time);
    end
    if (exp_dv) begin
      total++;
      if (w !== exp_word) begin
        bad++; $display("FAIL data_out: got %h want %h at %0t", w, exp_word, $time);
      end
      total++;
      if ({line_start, frame_start} !== {exp_ls, exp_fs}) begin
        bad++; $display("FAIL markers: got ls=%b fs=%b want ls=%b fs=%b at %0t",
                        line_start, frame_start, exp_ls, exp_fs, $time);
      end
    end else begin
      total++;
      if (line_start !== 1'b0 || frame_start !== 1'b0) begin
        bad++; $display("FAIL idle_markers: got ls=%b fs=%b want 0 0 at %0t",
                        line_start, frame_start, $time);
      end
    end
    if (data_valid === 1'b1) obs_q.push_back({line_start, frame_start, w});

    rgb_valid = v;
    rgb_in    = d;
    last_xfer = v && exp_ready;
    exp_dv    = 1'b0;
    if (last_xfer) begin
      if (m_line % 2 == 0) s = (m_pix % 2 == 0) ? d[23:16] : d[15:8];
      else                 s = (m_pix % 2 == 0) ? d[15:8]  : d[7:0];
      if (m_lane == 0) begin
        m_ls = (m_pix == 0);
        m_fs = (m_pix == 0) && (m_line == 0);
      end
      m_buf[m_lane] = s;
      if (m_lane == NUM_LANE - 1) begin
        exp_dv = 1'b1; exp_ls = m_ls; exp_fs = m_fs;
        for (int i = 0; i < NUM_LANE; i++) exp_word[i*8 +: 8] = m_buf[i];
        m_lane = 0;
      end else begin
        m_lane++;
      end
      m_pix++;
    end
    if (last_xfer && m_pix == LL) begin
      m_pix = 0; m_line = (m_line + 1) % FL; blank_left = HB; exp_ready = 1'b0;
    end else if (blank_left > 0) begin
      blank_left--; exp_ready = (blank_left == 0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    logic [WW-1:0] w;
    rst = 1'b1; rgb_valid = 1'b0; rgb_in = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      w = data_out;
      total++;
      if (rgb_ready !== 1'b0 || data_valid !== 1'b0 || line_start !== 1'b0 ||
          frame_start !== 1'b0 || w !== '0) begin
        bad++; $display("FAIL reset_outputs: got rdy=%b dv=%b ls=%b fs=%b dat=%h want all 0",
                        rgb_ready, data_valid, line_start, frame_start, w);
      end
    end
    rst = 1'b0;
    m_pix = 0; m_line = 0; m_lane = 0; blank_left = 0;
    exp_ready = 1'b1; exp_dv = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] d);
    int n = 0;
    last_xfer = 1'b0;
    while (!last_xfer && n < 20) begin
      cyc(1'b1, d);
      n++;
    end
    total++;
    if (!last_xfer) begin
      bad++; $display("FAIL send_timeout: got no transfer in %0d cycles want 1", n);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 24'($urandom));
  endtask

  task automatic check_word(input string name, input int idx, input logic [WW+1:0] want);
    total++;
    if (obs_q.size() <= idx) begin
      bad++; $display("FAIL %s: got %0d words want word %0d", name, obs_q.size(), idx);
    end else if (obs_q[idx] !== want) begin
      bad++; $display("FAIL %s: got %h want %h", name, obs_q[idx], want);
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    obs_q.delete();
  endtask

  task automatic test_colour_bars();
    int n_low = 0;
    obs_q.delete();
    send_pixel(24'h112233); send_pixel(24'h445566);
    send_pixel(24'h778899); send_pixel(24'hAABBCC);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 24'h0);
      if (!obs_ready) n_low++;
    end
    total++;
    if (n_low != HB) begin
      bad++; $display("FAIL blank_len: got %0d want %0d", n_low, HB);
    end
    check_word("bars_w0", 0, {1'b1, 1'b1, 16'h5511});
    check_word("bars_w1", 1, {1'b0, 1'b0, 16'hBB77});
  endtask

  task automatic test_odd_line();
    obs_q.delete();
    send_pixel(24'h112233); send_pixel(24'h445566);
    send_pixel(24'h778899); send_pixel(24'hAABBCC);
    idle(5);
    check_word("odd_w0", 0, {1'b1, 1'b0, 16'h6622});
    check_word("odd_w1", 1, {1'b0, 1'b0, 16'hCC88});
  endtask

  task automatic test_frame_wrap();
    logic [23:0] p [4];
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      p[i] = 24'($urandom);
      send_pixel(p[i]);
    end
    idle(5);
    check_word("wrap_w0", 0, {1'b1, 1'b1, p[1][15:8], p[0][23:16]});
    check_word("wrap_w1", 1, {1'b0, 1'b0, p[3][15:8], p[2][23:16]});
  endtask

  task automatic test_stalls();
    logic [23:0] a, b;
    a = 24'($urandom); b = 24'($urandom);
    obs_q.delete();
    cyc(1'b1, a);
    cyc(1'b0, 24'($urandom));
    cyc(1'b0, 24'($urandom));
    cyc(1'b1, b);
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL stall_early: got %0d words want 0", obs_q.size());
    end
    cyc(1'b0, 24'h0);
    check_word("stall_w0", 0, {1'b1, 1'b0, b[7:0], a[15:8]});
    send_pixel(24'($urandom)); send_pixel(24'($urandom));
    idle(5);
  endtask

  task automatic test_reset_mid();
    logic [23:0] p0, p1;
    send_pixel(24'($urandom));
    do_reset(2);
    obs_q.delete();
    p0 = 24'($urandom); p1 = 24'($urandom);
    send_pixel(p0); send_pixel(p1);
    idle(3);
    total++;
    if (obs_q.size() != 1) begin
      bad++; $display("FAIL rstmid_count: got %0d words want 1", obs_q.size());
    end
    check_word("rstmid_w0", 0, {1'b1, 1'b1, p1[15:8], p0[23:16]});
    send_pixel(24'($urandom)); send_pixel(24'($urandom));
    idle(5);
  endtask

  task automatic test_blank_ignore();
    logic [23:0] d [12];
    obs_q.delete();
    for (int c = 0; c < 12; c++) begin
      d[c] = 24'($urandom);
      cyc(1'b1, d[c]);
    end
    idle(2);
    // Line 1 occupies cycles 0..3, blanking 4..6, line 0 restarts at cycle 7.
    check_word("blank_w0", 0, {1'b1, 1'b0, d[1][7:0], d[0][15:8]});
    check_word("blank_w1", 1, {1'b0, 1'b0, d[3][7:0], d[2][15:8]});
    check_word("blank_w2", 2, {1'b1, 1'b1, d[8][15:8], d[7][23:16]});
    check_word("blank_w3", 3, {1'b0, 1'b0, d[10][15:8], d[9][23:16]});
    idle(5);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) cyc($urandom_range(0, 3) != 0, 24'($urandom));
    idle(6);
  endtask

  initial begin
    test_reset();
    test_colour_bars();
    test_odd_line();
    test_frame_wrap();
    test_stalls();
    test_reset_mid();
    test_blank_ignore();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
